axis_packet_buffer: RTL
=======================

AXIS_PACKET_BUFFER -- requirements
Module: axis_packet_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 4096, total word capacity (power of 2, >= 4).
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, equal to log2(DEPTH).
REQ-004 SHALL have parameter PACKET_MODE, default 0, where 0 is cut-through and 1 is store-and-forward.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: axis_aclk, axis_aresetn.
REQ-006 SHALL have port axis_aclk, input, 1, clock for all logic.
REQ-007 SHALL have port axis_aresetn, input, 1, async active-low reset.
REQ-008 SHALL have port s01_axis_wr_tdata, input, DATA_WIDTH, write data.
REQ-009 SHALL have port s01_axis_tstrb, input, DATA_WIDTH/8, byte qualifiers, stored with the word.
REQ-010 SHALL have port s01_axis_tvalid, input, 1, write word valid.
REQ-011 SHALL have port s01_axis_tlast, input, 1, last word of packet.
REQ-012 SHALL have port s01_axis_tready, output, 1, buffer can accept a word.
REQ-013 SHALL have port m01_axis_rd_tdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have port m01_axis_tstrb, output, DATA_WIDTH/8, stored tstrb of the presented word.
REQ-015 SHALL have port m01_axis_tvalid, output, 1, read word valid.
REQ-016 SHALL have port m01_axis_tlast, output, 1, stored tlast of the presented word.
REQ-017 SHALL have port m01_axis_tready, input, 1, downstream accepts the word.
REQ-018 SHALL have port fill_level, output, ADDR_WIDTH+1, words held, including the output stage.
REQ-019 SHALL have port pkt_count, output, ADDR_WIDTH+1, complete packets held.

Function
REQ-020 SHALL accept a write only on an edge with s01_axis_tvalid && s01_axis_tready, and s01_axis_tready SHALL equal (fill_level < DEPTH).
REQ-021 SHALL transfer a read only on an edge with m01_axis_tvalid && m01_axis_tready, and m01_axis_rd_tdata/tstrb/tlast SHALL hold steady while tvalid=1 and tready=0.
REQ-022 SHALL preserve word order, tstrb and tlast exactly, including words with tstrb=0.
REQ-023 SHALL, in cut-through mode, raise m01_axis_tvalid after edge N+2 for a word accepted at edge N into an empty buffer.
REQ-024 SHALL sustain one write and one read per cycle, with no bubbles in steady state.
REQ-025 SHALL, on a simultaneous accepted write and read, leave fill_level unchanged.
REQ-026 SHALL maintain read/write pointers mod DEPTH, wrapping from DEPTH-1 to 0 without a gap.
REQ-027 SHALL increment pkt_count on an accepted write with tlast=1, decrement it on an accepted read with tlast=1, and leave it unchanged when both occur together.
REQ-028 SHALL, in store-and-forward mode, assert m01_axis_tvalid only while pkt_count > 0 or fill_level == DEPTH (deadlock release for packets longer than DEPTH).
REQ-029 SHALL, when full, reassert s01_axis_tready on the cycle after the first accepted read.
REQ-030 SHALL update fill_level and pkt_count registered, one edge after the transfer.

Reset
REQ-031 SHALL, while axis_aresetn=0, asynchronously drive every output to 0: tready, tvalid, tdata, tstrb, tlast, fill_level, pkt_count.
REQ-032 SHALL raise s01_axis_tready on the first edge after reset deassertion.
REQ-033 SHALL discard all held words, including partial packets, on a reset mid-operation; RAM contents need not be cleared.

Structure
REQ-034 SHALL place in shared package axis_buf_pkg: the clog2 helper, mode constants MODE_CUT_THROUGH=0 and MODE_STORE_FWD=1, and the stored-word layout {tlast, tstrb, tdata}.
REQ-035 SHALL instantiate sub-module axis_buf_ram: simple dual-port RAM, synchronous read, width DATA_WIDTH + DATA_WIDTH/8 + 1, no reset.

Verification
REQ-036 SHALL cover cut-through: write 0x55, 0x22, 0x24 (tstrb=0xF, tlast=1 each), m01_axis_tready=0 -> fill_level=3 and pkt_count=3; then tready=1 -> 0x55, 0x22, 0x24 out in order, then fill_level=0.
REQ-037 SHALL cover store-and-forward: write 3 words with tlast only on the 3rd -> m01_axis_tvalid stays 0 until the edge after the 3rd write is accepted, then 3 back-to-back reads.
REQ-038 SHALL cover full/wrap with DEPTH=8: write 8 words -> tready=0; read 1 -> tready=1 next cycle; run 20 words through -> data intact across the pointer wrap.
REQ-039 SHALL cover simultaneous traffic: continuous write and read at fill_level=4 for 16 cycles -> fill_level stays 4 and pkt_count is constant.
REQ-040 SHALL cover reset mid-packet: assert reset after 2 of 5 words -> all outputs 0 immediately; after release fill_level=0 and the first new word is read correctly.
REQ-041 SHALL cover store-and-forward oversize: a 10-word packet with DEPTH=8 -> buffer fills, output released, all 10 words delivered with tlast on the 10th.

Source files
------------

// File: rtl/axis_buf_pkg.sv
// Shared definitions for the AXI-Stream packet buffer: mode constants,
// the stored-word layout and a constant-expression log2 helper.
package axis_buf_pkg;

    localparam int MODE_CUT_THROUGH = 0;
    localparam int MODE_STORE_FWD   = 1;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Each stored word is packed MSB-first as {tlast, tstrb, tdata}.
    function automatic int word_width(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// No reset; the read register holds its value while rd_en is low.
module axis_buf_ram
    import axis_buf_pkg::*;
#(
    parameter int  WIDTH = 37,
    parameter int  DEPTH = 4096,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_packet_buffer.sv
// AXI-Stream packet FIFO with cut-through or store-and-forward release.
// Words flow RAM -> read register (p1) -> output register (p2).
module axis_packet_buffer
    import axis_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4096,
    parameter int ADDR_WIDTH  = 12,
    parameter int PACKET_MODE = MODE_CUT_THROUGH
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s01_axis_wr_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_rd_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,
    output logic [ADDR_WIDTH:0]     fill_level,
    output logic [ADDR_WIDTH:0]     pkt_count
);

    localparam int                WORD_W     = word_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE        = 1;

    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0] fill_next, pkt_next;
    logic [WORD_W-1:0]   word_p0, word_p1, word_p2;
    logic                vld_p1, vld_p2;
    logic                wr_fire, rd_fire, ram_rd, load_p2, ram_has_data, release_ok;

    assign wr_fire      = s01_axis_tvalid && s01_axis_tready;
    assign rd_fire      = m01_axis_tvalid && m01_axis_tready;
    assign ram_has_data = (wr_ptr != rd_ptr);
    assign load_p2      = vld_p1 && (!vld_p2 || rd_fire);
    assign ram_rd       = ram_has_data && (!vld_p1 || load_p2);
    assign word_p0      = {s01_axis_tlast, s01_axis_tstrb, s01_axis_wr_tdata};

    axis_buf_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (axis_aclk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (word_p0),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (word_p1)
    );

    // A full buffer with no complete packet must still drain, or oversize packets deadlock.
    generate
        if (PACKET_MODE == MODE_STORE_FWD) begin : g_store_fwd
            assign release_ok = (pkt_count != '0) || (fill_level == FULL_LEVEL);
        end else begin : g_cut_through
            assign release_ok = 1'b1;
        end
    endgenerate

    assign m01_axis_tvalid = vld_p2 && release_ok;
    assign {m01_axis_tlast, m01_axis_tstrb, m01_axis_rd_tdata} = word_p2;

    always_comb begin
        fill_next = fill_level;
        pkt_next  = pkt_count;
        if (wr_fire && !rd_fire) begin
            fill_next = fill_level + ONE;
        end else if (!wr_fire && rd_fire) begin
            fill_next = fill_level - ONE;
        end
        if ((wr_fire && s01_axis_tlast) && !(rd_fire && m01_axis_tlast)) begin
            pkt_next = pkt_count + ONE;
        end else if (!(wr_fire && s01_axis_tlast) && (rd_fire && m01_axis_tlast)) begin
            pkt_next = pkt_count - ONE;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            vld_p1          <= 1'b0;
            vld_p2          <= 1'b0;
            word_p2         <= '0;
            fill_level      <= '0;
            pkt_count       <= '0;
            s01_axis_tready <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ONE;
            end
            // p1: RAM read register
            if (ram_rd) begin
                rd_ptr <= rd_ptr + ONE;
                vld_p1 <= 1'b1;
            end else if (load_p2) begin
                vld_p1 <= 1'b0;
            end
            // p2: output register
            if (load_p2) begin
                vld_p2  <= 1'b1;
                word_p2 <= word_p1;
            end else if (rd_fire) begin
                vld_p2 <= 1'b0;
            end
            fill_level      <= fill_next;
            pkt_count       <= pkt_next;
            s01_axis_tready <= (fill_next < FULL_LEVEL);
        end
    end

endmodule
